// File: rtl/hart_scheduler.sv
// rtl/hart_scheduler.sv - hazard-aware dispatch hart scheduler with round-robin or fixed-priority pick
module hart_scheduler #(
    parameter int NUM_HARTS    = 4,
    parameter int HART_W       = $clog2(NUM_HARTS),
    parameter int MODE         = 0,
    parameter int FLUSH_CYCLES = 2,
    parameter int MASTER_HART  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_i,
    input  logic [NUM_HARTS-1:0] request_i,
    input  logic [NUM_HARTS-1:0] hart_en_i,
    input  logic                 ld_issue_i,
    input  logic [HART_W-1:0]    ld_issue_hart_i,
    input  logic                 ld_done_i,
    input  logic [HART_W-1:0]    ld_done_hart_i,
    input  logic                 redirect_i,
    input  logic [HART_W-1:0]    redirect_hart_i,
    output logic [HART_W-1:0]    gnt_o,
    output logic                 gnt_valid_o,
    output logic [HART_W-1:0]    nxt_o,
    output logic                 nxt_valid_o,
    output logic [NUM_HARTS-1:0] stalled_o,
    output logic                 protocol_err_o
);

    typedef enum logic [1:0] {READY = 2'd0, LD_WAIT = 2'd1, FLUSH = 2'd2} hart_state_t;

    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    hart_state_t          state_q [NUM_HARTS];
    hart_state_t          state_d [NUM_HARTS];
    logic [3:0]           cnt_q   [NUM_HARTS];
    logic [3:0]           cnt_d   [NUM_HARTS];
    logic [NUM_HARTS-1:0] pend_q, pend_d;
    logic [NUM_HARTS-1:0] issue_hit, done_hit, redir_hit, eligible;
    logic [HART_W-1:0]    gnt_q, nxt_hart;
    logic                 gnt_valid_q, nxt_valid, err_q, err_d;

    // Wrap by explicit compare so non power-of-two hart counts never alias.
    function automatic int wrap_idx(input int base, input int k);
        int sum;
        sum = base + k;
        if (sum >= NUM_HARTS) sum = sum - NUM_HARTS;
        return sum;
    endfunction

    always_comb begin : decode
        issue_hit = '0;
        done_hit  = '0;
        redir_hit = '0;
        eligible  = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            issue_hit[h] = ld_issue_i && (ld_issue_hart_i == HART_W'(h));
            done_hit[h]  = ld_done_i  && (ld_done_hart_i  == HART_W'(h));
            redir_hit[h] = redirect_i && (redirect_hart_i == HART_W'(h));
            eligible[h]  = request_i[h] && hart_en_i[h] && (state_q[h] == READY);
        end
    end

    always_comb begin : hazard_next
        pend_d = pend_q;
        // An ld_done matching no hart (out-of-range index) is always illegal.
        err_d  = ld_done_i && (done_hit == '0);
        for (int h = 0; h < NUM_HARTS; h++) begin
            state_d[h] = state_q[h];
            cnt_d[h]   = cnt_q[h];
            case (state_q[h])
                READY: begin
                    if (issue_hit[h]) begin
                        state_d[h] = LD_WAIT;
                        pend_d[h]  = redir_hit[h];
                    end else if (redir_hit[h]) begin
                        state_d[h] = FLUSH;
                        cnt_d[h]   = CNT_LOAD;
                    end
                    if (done_hit[h]) err_d = 1'b1;
                end
                LD_WAIT: begin
                    if (done_hit[h] && !issue_hit[h]) begin
                        if (pend_q[h] || redir_hit[h]) begin
                            state_d[h] = FLUSH;
                            cnt_d[h]   = CNT_LOAD;
                            pend_d[h]  = 1'b0;
                        end else begin
                            state_d[h] = READY;
                        end
                    end else if (redir_hit[h]) begin
                        pend_d[h] = 1'b1;
                    end
                end
                FLUSH: begin
                    if (redir_hit[h])          cnt_d[h]   = CNT_LOAD;
                    else if (cnt_q[h] == 4'd0) state_d[h] = READY;
                    else                       cnt_d[h]   = cnt_q[h] - 4'd1;
                    if (done_hit[h]) err_d = 1'b1;
                end
                default: state_d[h] = READY;
            endcase
        end
    end

    // Loops run from the back of the search order so the first hit overwrites last.
    always_comb begin : pick
        nxt_hart  = gnt_q;
        nxt_valid = 1'b0;
        if (MODE == 1) begin
            for (int h = NUM_HARTS - 1; h >= 0; h--) begin
                if (eligible[h]) begin
                    nxt_hart  = HART_W'(h);
                    nxt_valid = 1'b1;
                end
            end
        end else begin
            for (int k = NUM_HARTS; k >= 1; k--) begin
                if (eligible[wrap_idx(int'(gnt_q), k)]) begin
                    nxt_hart  = HART_W'(wrap_idx(int'(gnt_q), k));
                    nxt_valid = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q       <= HART_W'(MASTER_HART);
            gnt_valid_q <= 1'b0;
            err_q       <= 1'b0;
            pend_q      <= '0;
            for (int h = 0; h < NUM_HARTS; h++) begin
                state_q[h] <= READY;
                cnt_q[h]   <= 4'd0;
            end
        end else begin
            if (enable_i) begin
                gnt_q       <= nxt_hart;
                gnt_valid_q <= nxt_valid;
            end
            err_q  <= err_d;
            pend_q <= pend_d;
            for (int h = 0; h < NUM_HARTS; h++) begin
                state_q[h] <= state_d[h];
                cnt_q[h]   <= cnt_d[h];
            end
        end
    end

    always_comb begin : stall_map
        stalled_o = '0;
        for (int h = 0; h < NUM_HARTS; h++) stalled_o[h] = (state_q[h] != READY);
    end

    assign gnt_o          = gnt_q;
    assign gnt_valid_o    = gnt_valid_q;
    assign nxt_o          = nxt_hart;
    assign nxt_valid_o    = nxt_valid;
    assign protocol_err_o = err_q;

endmodule

// File: tb/tb_hart_scheduler.sv
// tb/tb_hart_scheduler.sv - directed scoreboard bench for hart_scheduler
module tb_hart_scheduler;

    logic       clk, rst, enable;
    logic       ld_issue, ld_done, redirect;
    logic [1:0] ld_issue_hart, ld_done_hart, redirect_hart;
    logic [3:0] request, hart_en, request_m, hart_en_m;
    logic [2:0] request3, hart_en3;

    logic [1:0] gnt4, nxt4, gnt3, nxt3, gntm, nxtm;
    logic       gv4, nv4, perr4, gv3, nv3, perr3, gvm, nvm, perrm;
    logic [3:0] stalled4, stalledm;
    logic [2:0] stalled3;

    hart_scheduler u_dut (
        .clk(clk), .rst(rst), .enable_i(enable), .request_i(request), .hart_en_i(hart_en),
        .ld_issue_i(ld_issue), .ld_issue_hart_i(ld_issue_hart),
        .ld_done_i(ld_done), .ld_done_hart_i(ld_done_hart),
        .redirect_i(redirect), .redirect_hart_i(redirect_hart),
        .gnt_o(gnt4), .gnt_valid_o(gv4), .nxt_o(nxt4), .nxt_valid_o(nv4),
        .stalled_o(stalled4), .protocol_err_o(perr4)
    );

    hart_scheduler #(.NUM_HARTS(3), .MASTER_HART(2)) u_dut3 (
        .clk(clk), .rst(rst), .enable_i(enable), .request_i(request3), .hart_en_i(hart_en3),
        .ld_issue_i(ld_issue), .ld_issue_hart_i(ld_issue_hart),
        .ld_done_i(ld_done), .ld_done_hart_i(ld_done_hart),
        .redirect_i(redirect), .redirect_hart_i(redirect_hart),
        .gnt_o(gnt3), .gnt_valid_o(gv3), .nxt_o(nxt3), .nxt_valid_o(nv3),
        .stalled_o(stalled3), .protocol_err_o(perr3)
    );

    hart_scheduler #(.MODE(1)) u_dutm (
        .clk(clk), .rst(rst), .enable_i(enable), .request_i(request_m), .hart_en_i(hart_en_m),
        .ld_issue_i(ld_issue), .ld_issue_hart_i(ld_issue_hart),
        .ld_done_i(ld_done), .ld_done_hart_i(ld_done_hart),
        .redirect_i(redirect), .redirect_hart_i(redirect_hart),
        .gnt_o(gntm), .gnt_valid_o(gvm), .nxt_o(nxtm), .nxt_valid_o(nvm),
        .stalled_o(stalledm), .protocol_err_o(perrm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    string      tag_q [$];
    logic [3:0] exp_q [$];
    int         n_vec = 0;
    int         n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string tag, input logic [3:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check_v(input logic [3:0] obs);
        string      tag;
        logic [3:0] exp;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            tag = tag_q.pop_front();
            exp = exp_q.pop_front();
            assert (obs === exp)
            else begin
                n_err++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq4 [6];
        int seq3 [6];
        int seq_a [4];
        int seq_b [3];
        seq4  = '{1, 2, 3, 0, 1, 2};
        seq3  = '{0, 1, 2, 0, 1, 2};
        seq_a = '{0, 2, 3, 0};
        seq_b = '{3, 0, 1};

        rst = 1'b1; enable = 1'b0;
        request = '0; hart_en = '0; request3 = '0; hart_en3 = '0; request_m = '0; hart_en_m = '0;
        ld_issue = 1'b0; ld_done = 1'b0; redirect = 1'b0;
        ld_issue_hart = '0; ld_done_hart = '0; redirect_hart = '0;
        repeat (2) tick();
        rst = 1'b0;

        expect_v("rst_gnt", 4'd0);
        expect_v("rst_gnt_valid", 4'd0);
        expect_v("rst_stalled", 4'd0);
        expect_v("rst_perr", 4'd0);
        expect_v("rst_gnt_n3_master", 4'd2);
        check_v(4'(gnt4)); check_v(4'(gv4)); check_v(stalled4); check_v(4'(perr4)); check_v(4'(gnt3));

        // Round-robin sweep (N=4 and N=3) and fixed priority with request 1010
        request = 4'hf; hart_en = 4'hf; request3 = 3'b111; hart_en3 = 3'b111;
        request_m = 4'b1010; hart_en_m = 4'hf; enable = 1'b1;
        #1;
        expect_v("rr_nxt_lookahead", 4'd1);
        expect_v("rr_nxt_valid", 4'd1);
        check_v(4'(nxt4)); check_v(4'(nv4));
        for (int i = 0; i < 6; i++) begin
            expect_v($sformatf("rr_gnt_n4_%0d", i), 4'(seq4[i]));
            expect_v($sformatf("rr_gnt_valid_%0d", i), 4'd1);
            expect_v($sformatf("rr_gnt_n3_%0d", i), 4'(seq3[i]));
            expect_v($sformatf("prio_gnt_%0d", i), 4'd1);
            tick();
            check_v(4'(gnt4)); check_v(4'(gv4)); check_v(4'(gnt3)); check_v(4'(gntm));
        end

        // Enable low holds the grant
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_v($sformatf("hold_gnt_%0d", i), 4'd2);
            tick();
            check_v(4'(gnt4));
        end

        // Load stall on hart1: skipped until ld_done
        enable = 1'b1; ld_issue = 1'b1; ld_issue_hart = 2'd1;
        expect_v("ld_e0_gnt", 4'd3);
        expect_v("ld_e0_stalled", 4'b0010);
        tick();
        check_v(4'(gnt4)); check_v(stalled4);
        ld_issue = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_v($sformatf("ld_skip_gnt_%0d", i), 4'(seq_a[i]));
            expect_v($sformatf("ld_skip_stalled_%0d", i), 4'b0010);
            tick();
            check_v(4'(gnt4)); check_v(stalled4);
        end
        expect_v("ld_nxt_skips_hart1", 4'd2);
        check_v(4'(nxt4));
        ld_done = 1'b1; ld_done_hart = 2'd1;
        expect_v("ld_done_gnt", 4'd2);
        expect_v("ld_done_stalled", 4'b0000);
        expect_v("ld_done_perr", 4'd0);
        tick();
        check_v(4'(gnt4)); check_v(stalled4); check_v(4'(perr4));
        ld_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_v($sformatf("ld_resume_gnt_%0d", i), 4'(seq_b[i]));
            tick();
            check_v(4'(gnt4));
        end

        // Redirect hart2: flush lasts exactly two cycles
        enable = 1'b0; redirect = 1'b1; redirect_hart = 2'd2;
        expect_v("flush_c0", 4'b0100);
        tick();
        check_v(stalled4);
        redirect = 1'b0;
        expect_v("flush_c1", 4'b0100);
        tick();
        check_v(stalled4);
        expect_v("flush_done", 4'b0000);
        tick();
        check_v(stalled4);

        // Redirect while hart2 waits on a load: flush follows the ld_done
        ld_issue = 1'b1; ld_issue_hart = 2'd2;
        expect_v("pend_ldwait", 4'b0100);
        tick();
        check_v(stalled4);
        ld_issue = 1'b0; redirect = 1'b1; redirect_hart = 2'd2;
        expect_v("pend_redirect", 4'b0100);
        tick();
        check_v(stalled4);
        redirect = 1'b0;
        expect_v("pend_still_wait", 4'b0100);
        tick();
        check_v(stalled4);
        ld_done = 1'b1; ld_done_hart = 2'd2;
        expect_v("pend_flush_c0", 4'b0100);
        expect_v("pend_no_perr", 4'd0);
        tick();
        check_v(stalled4); check_v(4'(perr4));
        ld_done = 1'b0;
        expect_v("pend_flush_c1", 4'b0100);
        tick();
        check_v(stalled4);
        expect_v("pend_ready", 4'b0000);
        tick();
        check_v(stalled4);

        // Illegal ld_done: one-cycle pulse, no state change; out-of-range index on N=3
        ld_done = 1'b1; ld_done_hart = 2'd0;
        expect_v("perr_pulse", 4'd1);
        expect_v("perr_no_stall", 4'b0000);
        tick();
        check_v(4'(perr4)); check_v(stalled4);
        ld_done = 1'b0;
        expect_v("perr_clears", 4'd0);
        tick();
        check_v(4'(perr4));
        ld_done = 1'b1; ld_done_hart = 2'd3;
        expect_v("perr_out_of_range_n3", 4'd1);
        expect_v("oor_no_stall_n3", 4'b0000);
        tick();
        check_v(4'(perr3)); check_v(4'(stalled3));
        ld_done = 1'b0;

        // No eligible hart, then reset during LD_WAIT drops the load
        request = 4'h0; enable = 1'b1; ld_issue = 1'b1; ld_issue_hart = 2'd1;
        #1;
        expect_v("idle_nxt_valid", 4'd0);
        expect_v("idle_nxt_is_gnt", 4'd1);
        check_v(4'(nv4)); check_v(4'(nxt4));
        expect_v("idle_gnt_valid", 4'd0);
        expect_v("idle_gnt_hold", 4'd1);
        expect_v("pre_rst_stalled", 4'b0010);
        tick();
        check_v(4'(gv4)); check_v(4'(gnt4)); check_v(stalled4);
        ld_issue = 1'b0; rst = 1'b1;
        expect_v("midrst_stalled", 4'b0000);
        expect_v("midrst_gnt", 4'd0);
        expect_v("midrst_gnt_valid", 4'd0);
        expect_v("midrst_perr", 4'd0);
        tick();
        check_v(stalled4); check_v(4'(gnt4)); check_v(4'(gv4)); check_v(4'(perr4));
        rst = 1'b0; ld_done = 1'b1; ld_done_hart = 2'd1;
        expect_v("dropped_load_perr", 4'd1);
        tick();
        check_v(4'(perr4));
        ld_done = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
